// File: rtl/retire_stage.sv
// Retire stage: retires the longest in-order prefix of completed ROB exit entries,
// commits AMT updates, frees previous physical registers, and raises flush/halt.
// Optional macro RETIRE_ONE_BRANCH_EN: the scan stops after the first retiring branch.

package retire_pkg;

    // Default field widths of the ROB exit packet.
    localparam int AREG_W = 5;
    localparam int PREG_W = 6;

    typedef struct packed {
        logic              complete;
        logic              has_dest;
        logic [AREG_W-1:0] dest_areg;
        logic [PREG_W-1:0] dest_preg;
        logic [PREG_W-1:0] prev_preg;
        logic              mispredict;
        logic              halt;
`ifdef RETIRE_ONE_BRANCH_EN
        logic              is_branch;
`endif
        logic [31:0]       pc;
    } rob_exit_packet_t;

    typedef enum logic [1:0] {
        RUN,
        RECOVER,
        HALTED
    } retire_state_t;

endpackage

module retire_stage
    import retire_pkg::*;
#(
    parameter int N           = 3,
    parameter int ROB_SZ_BITS = 5,
    parameter int PREG_BITS   = PREG_W,
    parameter int AREG_BITS   = AREG_W,
    parameter int CNT_BITS    = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  rob_exit_packet_t [N-1:0]          rob_outputs,
    input  logic [$clog2(N+1)-1:0]            rob_outputs_valid,
    input  logic [ROB_SZ_BITS-1:0]            rob_head,
    output logic [$clog2(N+1)-1:0]            num_retiring,
    output logic [N-1:0]                      amt_we,
    output logic [N-1:0][AREG_BITS-1:0]       amt_areg,
    output logic [N-1:0][PREG_BITS-1:0]       amt_preg,
    output logic [N-1:0]                      free_valid,
    output logic [N-1:0][PREG_BITS-1:0]       free_preg,
    output logic                              tail_restore_valid,
    output logic [ROB_SZ_BITS-1:0]            tail_restore,
    output logic                              halted,
    output logic [CNT_BITS-1:0]               retired_count
);

    localparam int VALID_BITS = $clog2(N+1);

    retire_state_t state;
    logic          halt_hit;
    logic          mispredict_hit;
    logic          stop;
    logic          unused_pc;

    // Retire scan. Once a slot fails to retire, or retires a halt/mispredict
    // (or a branch when the branch limit is built in), no younger slot may retire.
    // NOTE: combinational blocks use blocking '=' and give every output a default
    // first, so the scan chains through 'stop' and no latch is inferred.
    always_comb begin
        num_retiring       = '0;
        amt_we             = '0;
        amt_areg           = '0;
        amt_preg           = '0;
        free_valid         = '0;
        free_preg          = '0;
        tail_restore_valid = 1'b0;
        tail_restore       = '0;
        halt_hit           = 1'b0;
        mispredict_hit     = 1'b0;
        stop               = reset || (state != RUN);

        for (int i = 0; i < N; i++) begin
            if (!stop && (i < int'(rob_outputs_valid)) && rob_outputs[i].complete) begin
                num_retiring = num_retiring + VALID_BITS'(1);
                if (rob_outputs[i].has_dest) begin
                    amt_we[i]     = 1'b1;
                    amt_areg[i]   = rob_outputs[i].dest_areg;
                    amt_preg[i]   = rob_outputs[i].dest_preg;
                    free_valid[i] = 1'b1;
                    free_preg[i]  = rob_outputs[i].prev_preg;
                end
                // Halt outranks mispredict on the same entry: no flush is requested.
                if (rob_outputs[i].halt) begin
                    halt_hit = 1'b1;
                    stop     = 1'b1;
                end else if (rob_outputs[i].mispredict) begin
                    mispredict_hit     = 1'b1;
                    tail_restore_valid = 1'b1;
                    tail_restore       = rob_head + ROB_SZ_BITS'(i + 1);
                    stop               = 1'b1;
                end
`ifdef RETIRE_ONE_BRANCH_EN
                if (rob_outputs[i].is_branch) begin
                    stop = 1'b1;
                end
`endif
            end else begin
                stop = 1'b1;
            end
        end
    end

    // The program counter travels with the packet but retirement has no use for it.
    always_comb begin
        unused_pc = 1'b0;
        for (int i = 0; i < N; i++) begin
            unused_pc = unused_pc ^ (^rob_outputs[i].pc);
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples the
    // pre-edge values of the scan regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RUN;
            halted        <= 1'b0;
            retired_count <= '0;
        end else begin
            retired_count <= retired_count + CNT_BITS'(num_retiring);
            case (state)
                RUN: begin
                    if (halt_hit) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (mispredict_hit) begin
                        state <= RECOVER;
                    end
                end
                RECOVER: state <= RUN;
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    a_retire_within_valid: assert property (@(posedge clock) disable iff (reset)
        num_retiring <= rob_outputs_valid);

    a_quiet_outside_run: assert property (@(posedge clock) disable iff (reset)
        (state != RUN) |-> (num_retiring == '0 && amt_we == '0 && free_valid == '0
                            && !tail_restore_valid));

    a_halted_matches_state: assert property (@(posedge clock) disable iff (reset)
        halted == (state == HALTED));

endmodule

// File: tb/tb_retire_stage.sv
// Scoreboard bench for retire_stage: the driver predicts each cycle's outputs from a
// prefix-retire model and queues them; a monitor pops and compares every cycle.
module tb_retire_stage;
    import retire_pkg::*;

    localparam int N = 3;

    logic                    clock;
    logic                    reset;
    rob_exit_packet_t [N-1:0] rob_outputs;
    logic [1:0]              rob_outputs_valid;
    logic [4:0]              rob_head;
    logic [1:0]              num_retiring;
    logic [N-1:0]            amt_we;
    logic [N-1:0][4:0]       amt_areg;
    logic [N-1:0][5:0]       amt_preg;
    logic [N-1:0]            free_valid;
    logic [N-1:0][5:0]       free_preg;
    logic                    tail_restore_valid;
    logic [4:0]              tail_restore;
    logic                    halted;
    logic [31:0]             retired_count;

    retire_stage dut (
        .clock              (clock),
        .reset              (reset),
        .rob_outputs        (rob_outputs),
        .rob_outputs_valid  (rob_outputs_valid),
        .rob_head           (rob_head),
        .num_retiring       (num_retiring),
        .amt_we             (amt_we),
        .amt_areg           (amt_areg),
        .amt_preg           (amt_preg),
        .free_valid         (free_valid),
        .free_preg          (free_preg),
        .tail_restore_valid (tail_restore_valid),
        .tail_restore       (tail_restore),
        .halted             (halted),
        .retired_count      (retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]        num;
        logic [N-1:0]      we;
        logic [N-1:0][4:0] areg;
        logic [N-1:0][5:0] apreg;
        logic [N-1:0]      fv;
        logic [N-1:0][5:0] fpreg;
        logic              trv;
        logic [4:0]        tr;
        logic              halted;
        logic [31:0]       count;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state: what the block has committed to so far.
    logic        m_halted  = 1'b0;
    logic        m_recover = 1'b0;
    logic [31:0] m_count   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic rob_exit_packet_t mk(input logic c, input logic hd,
                                            input logic mis, input logic hlt);
        rob_exit_packet_t p;
        p.complete   = c;
        p.has_dest   = hd;
        p.dest_areg  = 5'($urandom);
        p.dest_preg  = 6'($urandom);
        p.prev_preg  = 6'($urandom);
        p.mispredict = mis;
        p.halt       = hlt;
        p.pc         = $urandom;
        return p;
    endfunction

    function automatic rob_exit_packet_t rand_pkt();
        return mk($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 40) == 0);
    endfunction

    // Apply one cycle of stimulus and queue the outputs the block must show for it.
    task automatic drive(input logic rst, input rob_exit_packet_t [N-1:0] pk,
                         input logic [1:0] v, input logic [4:0] head);
        exp_t e;
        int   n;
        logic hit_halt;
        logic hit_mis;
        @(posedge clock);
        #1;
        reset             = rst;
        rob_outputs       = pk;
        rob_outputs_valid = v;
        rob_head          = head;

        e.num = '0; e.we = '0; e.areg = '0; e.apreg = '0; e.fv = '0; e.fpreg = '0;
        e.trv = 1'b0; e.tr = '0;
        e.halted = m_halted;
        e.count  = m_count;
        n = 0; hit_halt = 1'b0; hit_mis = 1'b0;
        if (!rst && !m_halted && !m_recover) begin
            while (n < int'(v) && n < N && pk[n].complete) begin
                if (pk[n].has_dest) begin
                    e.we[n]    = 1'b1;
                    e.areg[n]  = pk[n].dest_areg;
                    e.apreg[n] = pk[n].dest_preg;
                    e.fv[n]    = 1'b1;
                    e.fpreg[n] = pk[n].prev_preg;
                end
                n++;
                if (pk[n-1].halt) begin
                    hit_halt = 1'b1;
                    break;
                end
                if (pk[n-1].mispredict) begin
                    hit_mis = 1'b1;
                    e.trv   = 1'b1;
                    e.tr    = head + 5'(n);
                    break;
                end
            end
        end
        e.num = 2'(n);
        exp_q.push_back(e);

        if (rst) begin
            m_count = '0; m_halted = 1'b0; m_recover = 1'b0;
        end else begin
            m_count   = m_count + 32'(n);
            m_recover = hit_mis;
            if (hit_halt) m_halted = 1'b1;
        end
    endtask

    // Monitor: the block presents a result every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("num_retiring",       64'(num_retiring),       64'(e.num));
                check("amt_we",             64'(amt_we),             64'(e.we));
                check("amt_areg",           64'(amt_areg),           64'(e.areg));
                check("amt_preg",           64'(amt_preg),           64'(e.apreg));
                check("free_valid",         64'(free_valid),         64'(e.fv));
                check("free_preg",          64'(free_preg),          64'(e.fpreg));
                check("tail_restore_valid", 64'(tail_restore_valid), 64'(e.trv));
                if (e.trv) check("tail_restore", 64'(tail_restore), 64'(e.tr));
                check("halted",             64'(halted),             64'(e.halted));
                check("retired_count",      64'(retired_count),      64'(e.count));
            end
        end
    end

    initial begin
        rob_exit_packet_t [N-1:0] pk;
        rob_exit_packet_t         p;
        reset             = 1'b1;
        rob_outputs       = '0;
        rob_outputs_valid = '0;
        rob_head          = '0;

        pk = '0;
        drive(1'b1, pk, 2'd0, 5'd0);
        drive(1'b1, pk, 2'd0, 5'd0);

        // Three complete entries with destinations.
        for (int i = 0; i < N; i++) pk[i] = mk(1, 1, 0, 0);
        drive(1'b0, pk, 2'd3, 5'd4);
        // ROB empty.
        drive(1'b0, pk, 2'd0, 5'd7);
        // Hole in the middle: only slot 0 retires.
        pk[0] = mk(1, 1, 0, 0); pk[1] = mk(0, 1, 0, 0); pk[2] = mk(1, 1, 0, 0);
        drive(1'b0, pk, 2'd3, 5'd7);
        // Incomplete oldest entry blocks everything.
        pk[0] = mk(0, 1, 0, 0); pk[1] = mk(1, 1, 0, 0); pk[2] = mk(1, 1, 0, 0);
        drive(1'b0, pk, 2'd3, 5'd8);
        // Valid count limits retirement.
        for (int i = 0; i < N; i++) pk[i] = mk(1, 1, 0, 0);
        drive(1'b0, pk, 2'd2, 5'd9);
        // Mispredict in slot 1 with the tail wrapping past the top of the ROB.
        pk[1] = mk(1, 1, 1, 0);
        drive(1'b0, pk, 2'd3, 5'd31);
        for (int i = 0; i < N; i++) pk[i] = mk(1, 1, 0, 0);
        drive(1'b0, pk, 2'd3, 5'd2);
        drive(1'b0, pk, 2'd3, 5'd5);
        // Halt and mispredict on the same slot: halt wins.
        pk[0] = mk(1, 1, 1, 1); pk[1] = mk(1, 1, 0, 0); pk[2] = mk(1, 1, 0, 0);
        drive(1'b0, pk, 2'd3, 5'd10);
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) pk[i] = mk(1, 1, 0, 0);
            drive(1'b0, pk, 2'd3, 5'd11);
        end
        drive(1'b1, pk, 2'd3, 5'd0);
        // Youngest slot without destination, same areg repeated in the older two.
        pk[0] = mk(1, 1, 0, 0); pk[1] = mk(1, 1, 0, 0); pk[2] = mk(1, 0, 0, 0);
        pk[1].dest_areg = pk[0].dest_areg;
        drive(1'b0, pk, 2'd3, 5'd0);
        // Reset while recovering.
        pk[0] = mk(1, 1, 1, 0);
        drive(1'b0, pk, 2'd3, 5'd12);
        drive(1'b1, pk, 2'd3, 5'd0);
        drive(1'b0, pk, 2'd3, 5'd0);

        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                p = rand_pkt();
                pk[i] = p;
            end
            drive($urandom_range(0, 60) == 0, pk, 2'($urandom_range(0, 3)), 5'($urandom));
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clock);
        @(negedge clock);
        #1;
        if (exp_q.size() != 0) check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
